// File: rtl/fb_pkg.sv
// Shared frame buffer geometry and the rectangle-fill sequencer state type,
// used by the fill engine, the frame buffer and the scan-out logic.
package fb_pkg;
  localparam int FB_W      = 320;
  localparam int FB_H      = 240;
  localparam int FB_DATA_W = 16;
  localparam int FB_ADDR_W = 17;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    FILL  = 2'd2,
    DONE  = 2'd3
  } fb_state_t;
endpackage

// File: rtl/fb_rect_fill.sv
// Rectangle fill engine: clips a command to the frame and writes one pixel per
// cycle in raster order into the frame buffer system-clock write port.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// SETUP | clip extents and compute start address from latched command
// FILL  | one pixel write per cycle, raster order
// DONE  | one-cycle done pulse, then back to IDLE
module fb_rect_fill
  import fb_pkg::*;
#(
  parameter int W      = FB_W,
  parameter int H      = FB_H,
  parameter int DATA_W = FB_DATA_W,
  parameter int ADDR_W = FB_ADDR_W
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [8:0]        cmd_x,
  input  logic [7:0]        cmd_y,
  input  logic [8:0]        cmd_w,
  input  logic [7:0]        cmd_h,
  input  logic [DATA_W-1:0] cmd_color,
  output logic              fb_en,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [DATA_W-1:0] fb_din,
  output logic              busy,
  output logic              done
);

  localparam logic [9:0]        W_LIM  = 10'(W);
  localparam logic [8:0]        H_LIM  = 9'(H);
  localparam logic [ADDR_W-1:0] W_STEP = ADDR_W'(W);

  fb_state_t state;

  logic [8:0]        x_r;
  logic [7:0]        y_r;
  logic [8:0]        w_r;
  logic [7:0]        h_r;
  logic [DATA_W-1:0] color_r;

  logic [9:0]        w_eff;
  logic [8:0]        h_eff;
  logic [ADDR_W-1:0] start_addr;

  logic [9:0]        w_eff_r;
  logic [9:0]        col_left;
  logic [8:0]        row_left;
  logic [ADDR_W-1:0] row_base;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Clip against the right/bottom frame edges; an origin outside the frame yields 0.
  always_comb begin
    w_eff = '0;
    h_eff = '0;
    if ({1'b0, x_r} < W_LIM)
      w_eff = ({1'b0, w_r} < (W_LIM - {1'b0, x_r})) ? {1'b0, w_r} : (W_LIM - {1'b0, x_r});
    if ({1'b0, y_r} < H_LIM)
      h_eff = ({1'b0, h_r} < (H_LIM - {1'b0, y_r})) ? {1'b0, h_r} : (H_LIM - {1'b0, y_r});
    start_addr = ADDR_W'(y_r) * W_STEP + ADDR_W'(x_r);
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state    <= IDLE;
      fb_en    <= 1'b0;
      fb_we    <= 1'b0;
      fb_addr  <= '0;
      fb_din   <= '0;
      done     <= 1'b0;
      x_r      <= '0;
      y_r      <= '0;
      w_r      <= '0;
      h_r      <= '0;
      color_r  <= '0;
      w_eff_r  <= '0;
      col_left <= '0;
      row_left <= '0;
      row_base <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            x_r     <= cmd_x;
            y_r     <= cmd_y;
            w_r     <= cmd_w;
            h_r     <= cmd_h;
            color_r <= cmd_color;
            state   <= SETUP;
          end
        end
        SETUP: begin
          w_eff_r  <= w_eff;
          col_left <= w_eff - 10'd1;
          row_left <= h_eff - 9'd1;
          row_base <= start_addr;
          if (w_eff == '0 || h_eff == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state   <= FILL;
            fb_en   <= 1'b1;
            fb_we   <= 1'b1;
            fb_addr <= start_addr;
            fb_din  <= color_r;
          end
        end
        FILL: begin
          if (col_left == '0) begin
            if (row_left == '0) begin
              state <= DONE;
              done  <= 1'b1;
              fb_en <= 1'b0;
              fb_we <= 1'b0;
            end else begin
              // Next row starts from an accumulated base, no multiply per row.
              row_left <= row_left - 9'd1;
              col_left <= w_eff_r - 10'd1;
              row_base <= row_base + W_STEP;
              fb_addr  <= row_base + W_STEP;
            end
          end else begin
            col_left <= col_left - 10'd1;
            fb_addr  <= fb_addr + ADDR_W'(1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_rect_fill.sv
// Self-checking bench for fb_rect_fill: table of rectangle commands with
// hand-computed write counts and address ranges, plus back-to-back and reset cases.
module tb_fb_rect_fill;

  localparam int W_PIX = 320;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [8:0]  cmd_x;
  logic [7:0]  cmd_y;
  logic [8:0]  cmd_w;
  logic [7:0]  cmd_h;
  logic [15:0] cmd_color;
  logic        fb_en;
  logic        fb_we;
  logic [16:0] fb_addr;
  logic [15:0] fb_din;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

  fb_rect_fill dut (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .cmd_w     (cmd_w),
    .cmd_h     (cmd_h),
    .cmd_color (cmd_color),
    .fb_en     (fb_en),
    .fb_we     (fb_we),
    .fb_addr   (fb_addr),
    .fb_din    (fb_din),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [8:0]  x;
    logic [7:0]  y;
    logic [8:0]  w;
    logic [7:0]  h;
    logic [15:0] color;
    int          n;
    int          weff;
    int          first;
    int          last;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int idx, writes, first_w, done_at, done_cnt, busy_cnt;
    int addr_err, data_err, en_err, hold_err, last_addr, exp_addr;
    bit finished;
    writes = 0; first_w = -1; done_at = -1; done_cnt = 0; busy_cnt = 0;
    addr_err = 0; data_err = 0; en_err = 0; hold_err = 0; last_addr = -1;
    finished = 1'b0;
    @(negedge clk_sys);
    check({tag, "_ready"}, int'(cmd_ready), 1);
    cmd_x = v.x; cmd_y = v.y; cmd_w = v.w; cmd_h = v.h; cmd_color = v.color;
    cmd_valid = 1'b1;
    @(posedge clk_sys);
    @(negedge clk_sys);
    // Scramble the command inputs while busy; they must be ignored.
    cmd_valid = 1'b0;
    cmd_x = 9'h0AA; cmd_y = 8'h55; cmd_w = 9'h1FF; cmd_h = 8'hFF; cmd_color = 16'hA5A5;
    idx = 1;
    while (!finished && idx <= v.n + 20) begin
      if (busy) busy_cnt++;
      else finished = 1'b1;
      if (fb_en != fb_we) en_err++;
      if (fb_we) begin
        if (writes == 0) first_w = idx;
        if (v.weff == 0) addr_err++;
        else begin
          exp_addr = v.first + (writes / v.weff) * W_PIX + (writes % v.weff);
          if (int'(fb_addr) != exp_addr) addr_err++;
        end
        if (fb_din != v.color) data_err++;
        last_addr = int'(fb_addr);
        writes++;
      end
      if (done) begin
        done_cnt++;
        done_at = idx;
        if (v.n > 0 && (int'(fb_addr) != v.last || fb_din != v.color)) hold_err++;
      end
      if (!finished) begin
        @(negedge clk_sys);
        idx++;
      end
    end
    check({tag, "_terminated"}, int'(finished), 1);
    check({tag, "_writes"}, writes, v.n);
    check({tag, "_addr_err"}, addr_err, 0);
    check({tag, "_data_err"}, data_err, 0);
    check({tag, "_en_we_err"}, en_err, 0);
    check({tag, "_last_addr"}, last_addr, v.last);
    check({tag, "_first_write_cyc"}, first_w, (v.n > 0) ? 2 : -1);
    check({tag, "_done_cyc"}, done_at, v.n + 2);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_busy_cycles"}, busy_cnt, v.n + 2);
    check({tag, "_hold_err"}, hold_err, 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "global timeout");
  end

  initial begin
    int writes_seen, dones_seen, first_b, done_a, done_b, bad_a, addr9;
    int we_after, done_after;

    vecs[0] = '{9'd10,  8'd5,   9'd4,   8'd2,   16'hF800, 8,     4,   1610,  1933};
    vecs[1] = '{9'd316, 8'd239, 9'd10,  8'd5,   16'h07E0, 4,     4,   76796, 76799};
    vecs[2] = '{9'd10,  8'd5,   9'd0,   8'd2,   16'h1234, 0,     0,   -1,    -1};
    vecs[3] = '{9'd320, 8'd0,   9'd5,   8'd5,   16'h1234, 0,     0,   -1,    -1};
    vecs[4] = '{9'd0,   8'd240, 9'd5,   8'd1,   16'h1234, 0,     0,   -1,    -1};
    vecs[5] = '{9'd0,   8'd0,   9'd1,   8'd1,   16'hBEEF, 1,     1,   0,     0};
    vecs[6] = '{9'd300, 8'd230, 9'd50,  8'd50,  16'h5A5A, 200,   20,  73900, 76799};
    vecs[7] = '{9'd511, 8'd255, 9'd511, 8'd255, 16'hFFFF, 0,     0,   -1,    -1};
    vecs[8] = '{9'd0,   8'd0,   9'd320, 8'd240, 16'h001F, 76800, 320, 0,     76799};

    rst = 1'b1; cmd_valid = 1'b0;
    cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_en", int'(fb_en), 0);
    check("rst_we", int'(fb_we), 0);
    check("rst_addr", int'(fb_addr), 0);
    check("rst_din", int'(fb_din), 0);
    check("rst_done", int'(done), 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset wins over a simultaneous command.
    @(negedge clk_sys);
    cmd_x = 9'd1; cmd_y = 8'd1; cmd_w = 9'd2; cmd_h = 8'd2; cmd_color = 16'h0F0F;
    cmd_valid = 1'b1; rst = 1'b1;
    @(negedge clk_sys);
    check("rstpri_busy", int'(busy), 0);
    check("rstpri_ready", int'(cmd_ready), 1);
    cmd_valid = 1'b0; rst = 1'b0;
    we_after = 0;
    repeat (4) begin
      @(negedge clk_sys);
      if (fb_we || busy) we_after++;
    end
    check("rstpri_no_activity", we_after, 0);

    // Back-to-back: cmd_valid held high across two commands.
    @(negedge clk_sys);
    cmd_x = 9'd10; cmd_y = 8'd5; cmd_w = 9'd4; cmd_h = 8'd2; cmd_color = 16'hF800;
    cmd_valid = 1'b1;
    @(posedge clk_sys);
    @(negedge clk_sys);
    cmd_x = 9'd0; cmd_y = 8'd1; cmd_w = 9'd2; cmd_h = 8'd1; cmd_color = 16'h07E0;
    writes_seen = 0; dones_seen = 0; first_b = -1; done_a = -1; done_b = -1;
    bad_a = 0; addr9 = -1;
    for (int idx = 1; idx <= 20; idx++) begin
      if (fb_we) begin
        if (writes_seen < 8 && fb_din != 16'hF800) bad_a++;
        if (writes_seen == 8) begin
          first_b = idx;
          addr9 = int'(fb_addr);
        end
        writes_seen++;
        if (done) bad_a++;
      end
      if (done) begin
        if (dones_seen == 0) done_a = idx;
        else done_b = idx;
        dones_seen++;
      end
      if (idx == 11) check("b2b_ready_after_done", int'(cmd_ready), 1);
      if (idx == 12) cmd_valid = 1'b0;
      @(negedge clk_sys);
    end
    check("b2b_writes", writes_seen, 10);
    check("b2b_first_data_err", bad_a, 0);
    check("b2b_done_a", done_a, 10);
    check("b2b_first_b_write", first_b, 13);
    check("b2b_b_addr", addr9, 320);
    check("b2b_done_b", done_b, 15);
    check("b2b_done_count", dones_seen, 2);

    // Reset after three writes of a 4x2 fill.
    @(negedge clk_sys);
    cmd_x = 9'd10; cmd_y = 8'd5; cmd_w = 9'd4; cmd_h = 8'd2; cmd_color = 16'hF800;
    cmd_valid = 1'b1;
    @(posedge clk_sys);
    @(negedge clk_sys);
    cmd_valid = 1'b0;
    writes_seen = 0;
    for (int idx = 1; idx <= 4; idx++) begin
      if (fb_we) writes_seen++;
      if (idx < 4) @(negedge clk_sys);
    end
    check("rstfill_writes_before", writes_seen, 3);
    rst = 1'b1;
    @(negedge clk_sys);
    check("rstfill_we", int'(fb_we), 0);
    check("rstfill_ready", int'(cmd_ready), 1);
    check("rstfill_addr", int'(fb_addr), 0);
    rst = 1'b0;
    we_after = 0; done_after = 0;
    repeat (8) begin
      if (fb_we) we_after++;
      if (done) done_after++;
      @(negedge clk_sys);
    end
    check("rstfill_no_writes", we_after, 0);
    check("rstfill_no_done", done_after, 0);
    run_vec(vecs[0], "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
